// File: rtl/layer_2_channel_packer.sv
// Serial-to-parallel channel packer for the layer 2 feature-map stream.
// Define PACKER_LAST_EN to add the end-of-row flag last_out.
module layer_2_channel_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH = 16,
  parameter int IMG_SIZE = 208,
  localparam int DATA_OUT_WIDTH = DATA_WIDTH * NUM_CH
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      start,
  input  logic [DATA_WIDTH-1:0]     ch_data,
  input  logic                      ch_valid,
  output logic                      ch_ready,
  output logic [DATA_OUT_WIDTH-1:0] data_out,
  output logic                      valid_out,
  output logic                      busy,
  output logic                      frame_done
`ifdef PACKER_LAST_EN
  ,
  output logic                      last_out
`endif
);

  localparam int CW = $clog2(NUM_CH);
  localparam int PW = $clog2(IMG_SIZE * IMG_SIZE);
  localparam int AW = DATA_WIDTH * (NUM_CH - 1);
  localparam logic [CW-1:0] CH_LAST = CW'(NUM_CH - 1);
  localparam logic [PW-1:0] PX_LAST = PW'(IMG_SIZE * IMG_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE,
    PACK,
    DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   ch_cnt;
  logic [PW-1:0]   px_cnt;
  logic [AW-1:0]   assembly;
  logic            xfer;

`ifdef PACKER_LAST_EN
  localparam int RW = $clog2(IMG_SIZE);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_SIZE - 1);
  logic [RW-1:0]   row_cnt;
`endif

  assign xfer = ch_valid && ch_ready;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= IDLE;
      ch_cnt     <= '0;
      px_cnt     <= '0;
      assembly   <= '0;
      data_out   <= '0;
      ch_ready   <= 1'b0;
      valid_out  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef PACKER_LAST_EN
      row_cnt    <= '0;
      last_out   <= 1'b0;
`endif
    end else begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
`ifdef PACKER_LAST_EN
      last_out   <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= PACK;
            ch_cnt   <= '0;
            px_cnt   <= '0;
            ch_ready <= 1'b1;
            busy     <= 1'b1;
`ifdef PACKER_LAST_EN
            row_cnt  <= '0;
`endif
          end
        end
        PACK: begin
          if (xfer) begin
            if (ch_cnt == CH_LAST) begin
              // final channel bypasses the slots straight into the word
              data_out  <= {ch_data, assembly};
              valid_out <= 1'b1;
              ch_cnt    <= '0;
              px_cnt    <= px_cnt + 1'b1;
`ifdef PACKER_LAST_EN
              last_out  <= (row_cnt == ROW_LAST);
              row_cnt   <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
`endif
              if (px_cnt == PX_LAST) begin
                state    <= DONE;
                ch_ready <= 1'b0;
              end
            end else begin
              for (int i = 0; i < NUM_CH - 1; i++) begin
                if (ch_cnt == CW'(i)) begin
                  assembly[i*DATA_WIDTH +: DATA_WIDTH] <= ch_data;
                end
              end
              ch_cnt <= ch_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          frame_done <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_2_channel_packer.sv
// Directed bench for layer_2_channel_packer with a 4x4 frame.
// Define PACKER_LAST_EN to also check last_out.
module tb_layer_2_channel_packer;

  localparam int DW  = 32;
  localparam int NC  = 16;
  localparam int IS  = 4;
  localparam int OW  = DW * NC;
  localparam int NPX = IS * IS;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          start;
  logic [DW-1:0] ch_data;
  logic          ch_valid;
  logic          ch_ready;
  logic [OW-1:0] data_out;
  logic          valid_out;
  logic          busy;
  logic          frame_done;
`ifdef PACKER_LAST_EN
  logic          last_out;
`endif

  layer_2_channel_packer #(
    .DATA_WIDTH(DW),
    .NUM_CH(NC),
    .IMG_SIZE(IS)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .start(start),
    .ch_data(ch_data),
    .ch_valid(ch_valid),
    .ch_ready(ch_ready),
    .data_out(data_out),
    .valid_out(valid_out),
    .busy(busy),
    .frame_done(frame_done)
`ifdef PACKER_LAST_EN
    ,
    .last_out(last_out)
`endif
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int            vcnt = 0;
  int            vcyc[256];
  logic [OW-1:0] vword[256];
  logic          vlast[256];
  int            fdcnt = 0;
  int            fdcyc = 0;

  always @(negedge Clk) begin
    if (valid_out === 1'b1) begin
      if (vcnt < 256) begin
        vcyc[vcnt]  = cyc;
        vword[vcnt] = data_out;
`ifdef PACKER_LAST_EN
        vlast[vcnt] = last_out;
`else
        vlast[vcnt] = 1'b0;
`endif
      end
      vcnt++;
    end
    if (frame_done === 1'b1) begin
      fdcnt++;
      fdcyc = cyc;
    end
  end

  int tests = 0;
  int fails = 0;
  int lastacc = 0;

  function automatic logic [OW-1:0] pw(input logic [DW-1:0] b);
    logic [OW-1:0] w;
    for (int c = 0; c < NC; c++) w[c*DW +: DW] = b + DW'(c);
    return w;
  endfunction

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset;
    Rst = 1'b1;
    start = 1'b0;
    ch_valid = 1'b0;
    ch_data = '0;
    tick;
    tick;
    Rst = 1'b0;
  endtask

  task automatic go;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic beat(input logic [DW-1:0] d, input bit gappy);
    int n;
    n = gappy ? int'($urandom_range(0, 2)) : 0;
    ch_valid = 1'b0;
    repeat (n) tick;
    tests++;
    if (ch_ready !== 1'b1) begin
      fails++;
      $display("FAIL beat_ready: ch_ready=%b want 1", ch_ready);
    end
    ch_data = d;
    ch_valid = 1'b1;
    tick;
    lastacc = cyc;
    ch_valid = 1'b0;
  endtask

  task automatic pixel(input logic [DW-1:0] b, input bit gappy);
    for (int c = 0; c < NC; c++) beat(b + DW'(c), gappy);
  endtask

  task automatic test_reset;
    Rst = 1'b1;
    start = 1'b1;
    ch_valid = 1'b1;
    ch_data = 32'hDEADBEEF;
    tick;
    tick;
    tests += 5;
    if (ch_ready !== 1'b0) begin
      fails++; $display("FAIL rst_ready: got %b want 0", ch_ready);
    end
    if (valid_out !== 1'b0) begin
      fails++; $display("FAIL rst_valid: got %b want 0", valid_out);
    end
    if (busy !== 1'b0) begin
      fails++; $display("FAIL rst_busy: got %b want 0", busy);
    end
    if (frame_done !== 1'b0) begin
      fails++; $display("FAIL rst_done: got %b want 0", frame_done);
    end
    if (data_out !== '0) begin
      fails++; $display("FAIL rst_data: got %h want 0", data_out);
    end
    Rst = 1'b0;
    start = 1'b0;
    ch_valid = 1'b0;
    tick;
  endtask

  task automatic test_first_pixel;
    int b;
    do_reset;
    go;
    b = vcnt;
    for (int c = 0; c < NC - 1; c++) beat(32'h3F800000 + DW'(c), 1'b0);
    beat(32'h3F80000F, 1'b0);
    tests += 3;
    if (vcnt !== b) begin
      fails++; $display("FAIL early_valid: pulses %0d want 0", vcnt - b);
    end
    if (valid_out !== 1'b1) begin
      fails++; $display("FAIL lat1_valid: got %b want 1", valid_out);
    end
    if (ch_ready !== 1'b1) begin
      fails++; $display("FAIL emit_ready: got %b want 1", ch_ready);
    end
    tick;
    tests += 5;
    if (vcnt - b !== 1) begin
      fails++; $display("FAIL px0_count: got %0d want 1", vcnt - b);
    end
    if (vcyc[b] !== lastacc) begin
      fails++; $display("FAIL px0_lat: got %0d want %0d", vcyc[b], lastacc);
    end
    if (vword[b][31:0] !== 32'h3F800000) begin
      fails++; $display("FAIL px0_ch0: got %h want 3f800000", vword[b][31:0]);
    end
    if (vword[b][511:480] !== 32'h3F80000F) begin
      fails++; $display("FAIL px0_ch15: got %h want 3f80000f", vword[b][511:480]);
    end
    if (vword[b] !== pw(32'h3F800000)) begin
      fails++; $display("FAIL px0_word: got %h want %h", vword[b], pw(32'h3F800000));
    end
  endtask

  task automatic test_full_frame;
    int b;
    int f0;
    do_reset;
    go;
    b = vcnt;
    f0 = fdcnt;
    for (int p = 0; p < NPX; p++) pixel(32'h10000000 + DW'(p * 256), 1'b0);
    tick;
    tick;
    tick;
    tests += 6;
    if (vcnt - b !== NPX) begin
      fails++; $display("FAIL frame_count: got %0d want %0d", vcnt - b, NPX);
    end
    if (fdcnt - f0 !== 1) begin
      fails++; $display("FAIL frame_done_cnt: got %0d want 1", fdcnt - f0);
    end
    if (fdcyc !== vcyc[b+NPX-1] + 1) begin
      fails++; $display("FAIL frame_done_at: got %0d want %0d", fdcyc, vcyc[b+NPX-1] + 1);
    end
    if (ch_ready !== 1'b0) begin
      fails++; $display("FAIL frame_ready: got %b want 0", ch_ready);
    end
    if (busy !== 1'b0) begin
      fails++; $display("FAIL frame_busy: got %b want 0", busy);
    end
    if (vword[b+NPX-1] !== pw(32'h10000F00)) begin
      fails++; $display("FAIL frame_last_word: got %h want %h", vword[b+NPX-1], pw(32'h10000F00));
    end
    for (int i = 1; i < NPX; i++) begin
      tests++;
      if (vcyc[b+i] - vcyc[b+i-1] !== NC) begin
        fails++;
        $display("FAIL frame_gap%0d: got %0d want %0d", i, vcyc[b+i] - vcyc[b+i-1], NC);
      end
    end
`ifdef PACKER_LAST_EN
    for (int i = 0; i < NPX; i++) begin
      tests++;
      if (vlast[b+i] !== ((i % IS) == IS - 1)) begin
        fails++;
        $display("FAIL last_out%0d: got %b want %b", i, vlast[b+i], (i % IS) == IS - 1);
      end
    end
`endif
  endtask

  task automatic test_gaps;
    int b;
    do_reset;
    go;
    b = vcnt;
    for (int c = 0; c < NC - 1; c++) beat(32'h3F800000 + DW'(c), 1'b1);
    tests += 2;
    if (vcnt !== b) begin
      fails++; $display("FAIL gap_early: pulses %0d want 0", vcnt - b);
    end
    if (valid_out !== 1'b0) begin
      fails++; $display("FAIL gap_valid: got %b want 0", valid_out);
    end
    beat(32'h3F80000F, 1'b1);
    tick;
    tests += 2;
    if (vword[b] !== pw(32'h3F800000)) begin
      fails++; $display("FAIL gap_word: got %h want %h", vword[b], pw(32'h3F800000));
    end
    if (vcyc[b] !== lastacc) begin
      fails++; $display("FAIL gap_lat: got %0d want %0d", vcyc[b], lastacc);
    end
  endtask

  task automatic test_reset_mid;
    int b;
    int f0;
    do_reset;
    go;
    pixel(32'hA0000000, 1'b0);
    pixel(32'hA0000100, 1'b0);
    for (int c = 0; c < 7; c++) beat(32'hA0000200 + DW'(c), 1'b0);
    b = vcnt;
    Rst = 1'b1;
    start = 1'b1;
    ch_valid = 1'b1;
    ch_data = 32'hA0000207;
    tick;
    Rst = 1'b0;
    start = 1'b0;
    ch_valid = 1'b0;
    repeat (20) tick;
    tests += 4;
    if (vcnt !== b) begin
      fails++; $display("FAIL mid_pulse: pulses %0d want 0", vcnt - b);
    end
    if (data_out !== '0) begin
      fails++; $display("FAIL mid_data: got %h want 0", data_out);
    end
    if (busy !== 1'b0) begin
      fails++; $display("FAIL mid_busy: got %b want 0", busy);
    end
    if (ch_ready !== 1'b0) begin
      fails++; $display("FAIL mid_ready: got %b want 0", ch_ready);
    end
    go;
    f0 = fdcnt;
    for (int p = 0; p < NPX; p++) pixel(32'h50000000 + DW'(p * 256), 1'b0);
    tick;
    tick;
    tests += 4;
    if (vword[b] !== pw(32'h50000000)) begin
      fails++; $display("FAIL post_word: got %h want %h", vword[b], pw(32'h50000000));
    end
    if (vcnt - b !== NPX) begin
      fails++; $display("FAIL post_count: got %0d want %0d", vcnt - b, NPX);
    end
    if (fdcnt - f0 !== 1) begin
      fails++; $display("FAIL post_done_cnt: got %0d want 1", fdcnt - f0);
    end
    if (fdcyc !== vcyc[b+NPX-1] + 1) begin
      fails++; $display("FAIL post_done_at: got %0d want %0d", fdcyc, vcyc[b+NPX-1] + 1);
    end
  endtask

  task automatic test_start_ignored;
    int b;
    int f0;
    do_reset;
    go;
    b = vcnt;
    f0 = fdcnt;
    for (int p = 0; p < NPX; p++) begin
      for (int c = 0; c < NC; c++) begin
        start = (p == 5 && c == 3);
        beat(32'h70000000 + DW'(p * 256 + c), 1'b0);
        start = 1'b0;
      end
    end
    start = 1'b1;
    tick;
    start = 1'b0;
    tests += 3;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL done_start_busy: got %b want 0", busy);
    end
    if (ch_ready !== 1'b0) begin
      fails++; $display("FAIL done_start_ready: got %b want 0", ch_ready);
    end
    if (frame_done !== 1'b1) begin
      fails++; $display("FAIL ign_done_pulse: got %b want 1", frame_done);
    end
    go;
    tests += 5;
    if (ch_ready !== 1'b1) begin
      fails++; $display("FAIL restart_ready: got %b want 1", ch_ready);
    end
    if (busy !== 1'b1) begin
      fails++; $display("FAIL restart_busy: got %b want 1", busy);
    end
    if (vcnt - b !== NPX) begin
      fails++; $display("FAIL ign_count: got %0d want %0d", vcnt - b, NPX);
    end
    if (fdcnt - f0 !== 1) begin
      fails++; $display("FAIL ign_done_cnt: got %0d want 1", fdcnt - f0);
    end
    if (fdcyc !== vcyc[b+NPX-1] + 1) begin
      fails++; $display("FAIL ign_done_at: got %0d want %0d", fdcyc, vcyc[b+NPX-1] + 1);
    end
    tick;
    tick;
    tests++;
    if (fdcnt - f0 !== 1) begin
      fails++; $display("FAIL extra_done: got %0d want 1", fdcnt - f0);
    end
  endtask

  initial begin
    Rst = 1'b1;
    start = 1'b0;
    ch_valid = 1'b0;
    ch_data = '0;
    test_reset;
    test_first_pixel;
    test_full_frame;
    test_gaps;
    test_reset_mid;
    test_start_ignored;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/layer_2_channel_packer.md
Name: layer_2_channel_packer

Overview:
- Producer side of the packed multi-channel feature-map stream that the layer featuremap blocks consume.
- Accepts one 32-bit float per channel, serially, over a valid/ready handshake.
- Assembles NUM_CH channels into one wide pixel word and pushes it with a single-cycle valid pulse, in raster order, for one IMG_SIZE x IMG_SIZE frame per start command.
- Sits between the previous layer's output buffer reader and the layer 2 featuremap instances.

Parameters:
- DATA_WIDTH, 32, width of one channel sample (IEEE-754 single).
- NUM_CH, 16, channels packed per pixel word.
- IMG_SIZE, 208, frame width and height in pixels.
- DATA_OUT_WIDTH, DATA_WIDTH*NUM_CH (512), packed word width; derived, not overridden.

Ports:
- Clk  input  1  clock; all logic on the rising edge.
- Rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle frame start request; honoured only in IDLE.
- ch_data  input  DATA_WIDTH  channel sample; arrival order is channel 0 first.
- ch_valid  input  1  ch_data is valid.
- ch_ready  output  1  packer accepts ch_data this cycle.
- data_out  output  DATA_OUT_WIDTH  packed pixel; channel c occupies bits [DATA_WIDTH*c+DATA_WIDTH-1 : DATA_WIDTH*c].
- valid_out  output  1  one-cycle pulse when data_out holds a new pixel; push-only, with no backpressure from the consumer.
- busy  output  1  high in PACK and DONE.
- frame_done  output  1  one-cycle pulse after the last pixel of the frame is emitted.

Behaviour:
- Reset values: ch_ready=0, valid_out=0, busy=0, frame_done=0, data_out=0; state=IDLE; ch_cnt=0; px_cnt=0; assembly register=0.
- Counters:
  - ch_cnt is $clog2(NUM_CH) bits.
  - px_cnt is $clog2(IMG_SIZE*IMG_SIZE) bits (16 bits for 43264 pixels).
- State IDLE:
  - ch_ready=0.
  - start=1 -> PACK; ch_cnt and px_cnt are cleared.
- State PACK:
  - ch_ready=1 continuously. A transfer is a cycle with ch_valid && ch_ready.
  - For a transfer with ch_cnt<NUM_CH-1: write ch_data into assembly slot ch_cnt, then ch_cnt++.
  - For a transfer with ch_cnt==NUM_CH-1: data_out <= {ch_data, assembly slots NUM_CH-2..0}; valid_out=1 on the next cycle; ch_cnt wraps to 0; px_cnt++.
- Throughput and latency:
  - No bubble between pixels. ch_ready stays high through the emitting beat, so slot 0 of the next pixel may be accepted on the same cycle valid_out is high.
  - Latency is 1 cycle from the accepting edge of channel NUM_CH-1 to valid_out.
- Gaps: ch_valid=0 cycles stall assembly with no state change. Partial pixels are held indefinitely.
- Last pixel: when the transfer completing px_cnt==IMG_SIZE*IMG_SIZE-1 occurs -> DONE. ch_ready drops on the following cycle, the same cycle valid_out pulses.
- State DONE:
  - frame_done=1 for exactly one cycle, one cycle after the final valid_out.
  - Then -> IDLE.
- data_out holds its last value between pulses. It changes only on the emitting edge or on reset.
- start outside IDLE is ignored, with no restart and no counter clear. start on the same cycle as the DONE->IDLE transition is also ignored.
- Rst asserted mid-frame: on the next edge all state returns to the reset values, the partial pixel is discarded, and no valid_out or frame_done is issued.
- Rst dominates start and ch_valid on the same cycle.

Optional Feature:
- Macro: PACKER_LAST_EN.
- Defined: adds output port last_out (1 bit).
  - last_out is high with valid_out for the final pixel of each row, i.e. the pixel index with px mod IMG_SIZE == IMG_SIZE-1.
  - Otherwise last_out is 0; reset value 0.
  - A row-position counter of $clog2(IMG_SIZE) bits is added, cleared on start and on reset.
- Not defined: the last_out port and the row counter are absent. All other behaviour is identical.

Test Plan:
- Reset then start, with 16 back-to-back beats ch_data=32'h3F800000+c for c=0..15 -> valid_out high exactly 1 cycle after beat 15; data_out[31:0]=32'h3F800000 and data_out[511:480]=32'h3F80000F; ch_ready stays 1.
- Full frame with IMG_SIZE=4, continuous ch_valid -> exactly 16 valid_out pulses, spaced 16 cycles apart; frame_done pulses once, 1 cycle after the 16th pulse; ch_ready=0 afterward; busy returns to 0.
- Random ch_valid gaps (~50% duty) over one pixel -> packed word is identical to the gap-free case; no valid_out until all 16 channels are accepted.
- Rst asserted after 7 beats of pixel 2, then start, then a fresh frame -> no pulse from the partial pixel; the new frame's first data_out contains only post-reset data; px_cnt restarts at 0.
- start pulsed during PACK and on the DONE cycle -> ignored; pixel count and frame_done timing are unchanged; a start one cycle after returning to IDLE begins a new frame.
- PACKER_LAST_EN defined, IMG_SIZE=4 -> last_out high on valid_out pulses 4, 8, 12 and 16 only; with the macro undefined the design elaborates without last_out.
